// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register plus instruction-fetch stage.
// Owns the fetch PC and issues one instruction-memory request at a time
// over a req/gnt/rvalid handshake. It also loads the IF/ID pipeline register.
// On a redirect, any response still in flight is dropped.
// A response that arrives while decode is stalled is parked in a one-entry
// skid buffer until the stall clears.

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  // next-PC logic
  input  logic [31:0] npc,
  input  logic        redirect,
  // hazard unit
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] pc,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // IF/ID pipeline register
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  // Fetch sequencer states.
  // REQ  : request is being presented and is waiting for gnt.
  // WAIT : request was granted and its response is expected.
  // DROP : a granted response is outstanding but is stale after a redirect.
  // FULL : the skid buffer holds a response that arrived during a stall.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
  localparam logic [2:0] S_FULL = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;

  logic        deliver;
  logic [31:0] deliver_instr;

  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;

  // Fetch sequencer: next state, next PC, skid capture and the deliver strobe.
  always_comb begin
    // NOTE: every signal assigned here gets a default first. A path that
    // leaves a signal unassigned would otherwise infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    skid_d        = skid_q;
    deliver       = 1'b0;
    deliver_instr = skid_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect) begin
          // The address may move before gnt arrives. If gnt lands in the
          // same cycle, the accepted request is for the old PC, so its
          // response must be dropped.
          pc_d    = npc;
          state_d = imem_gnt ? S_DROP : S_REQ;
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          // A response in this same cycle is discarded on the spot.
          // Otherwise it is still in flight and must be dropped later.
          pc_d    = npc;
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          if (!stall) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            state_d       = S_REQ;
          end else begin
            skid_d  = imem_rdata;
            state_d = S_FULL;
          end
        end
      end

      S_DROP: begin
        // A redirect here only moves the PC. The stale response is still
        // pending and is discarded whenever it shows up.
        if (redirect) begin
          pc_d = npc;
        end
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end

      S_FULL: begin
        if (redirect) begin
          skid_d  = NOP_INSTR;
          pc_d    = npc;
          state_d = S_REQ;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = skid_q;
          state_d       = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A delivered instruction retires its PC, so fetch moves on.
    if (deliver) begin
      pc_d = npc;
    end
  end

  // IF/ID load priority: kill (redirect/flush), then deliver, then hold on
  // stall. Any other cycle is a bubble.
  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    if (redirect || flush) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
    end else if (deliver) begin
      if_id_pc_d    = pc_q;
      if_id_instr_d = deliver_instr;
      if_id_valid_d = 1'b1;
    end else if (stall) begin
      if_id_valid_d = if_id_valid_q;
    end else begin
      if_id_valid_d = 1'b0;
    end
  end

  // Fetch-side state registers: sequencer state, PC and skid buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the skid buffer is a single register, not a memory, so it is
      // cheap to reset. Resetting it keeps its contents deterministic.
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      skid_q  <= NOP_INSTR;
    end else begin
      // NOTE: state updates use non-blocking assignments. Every register
      // then samples the pre-edge values, whatever order the blocks run in.
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_id_pc_q    <= 32'h0000_0000;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  // Outputs: the address always mirrors the PC, and a request is only
  // presented in REQ.
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == S_REQ);
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit.
// The bench plays the next-PC logic (npc = pc + 4, or tgt on redirect),
// the hazard unit and the instruction memory.
// Expected values are hand-computed constants.

module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0010_0093;
  localparam logic [31:0] I1  = 32'h0020_0113;
  localparam logic [31:0] I2  = 32'h0030_0193;
  localparam logic [31:0] I3  = 32'h0040_0213;
  localparam logic [31:0] I4  = 32'h0050_0293;
  localparam logic [31:0] I5  = 32'h0060_0313;
  localparam logic [31:0] BAD = 32'hdead_beef;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] npc;
  logic        redirect;
  logic        stall;
  logic        flush;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] tgt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Next-PC logic stand-in.
  assign npc = redirect ? tgt : pc + 32'd4;

  pc_fetch_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .npc         (npc),
    .redirect    (redirect),
    .stall       (stall),
    .flush       (flush),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if_id(input string tag, input logic [31:0] e_pc,
                             input logic [31:0] e_instr, input logic e_valid);
    check({tag, "_ifid_pc"},    if_id_pc,              e_pc);
    check({tag, "_ifid_instr"}, if_id_instr,           e_instr);
    check({tag, "_ifid_valid"}, {31'd0, if_id_valid},  {31'd0, e_valid});
  endtask

  // One undisturbed fetch starting in REQ: gnt now, rvalid next cycle.
  task automatic fetch(input string tag, input logic [31:0] instr, input logic [31:0] exp_pc);
    check({tag, "_req"},  {31'd0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr,         exp_pc);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    check({tag, "_wait_req"},    {31'd0, imem_req},    32'd0);
    check({tag, "_wait_bubble"}, {31'd0, if_id_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = instr;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = BAD;
    check_if_id(tag, exp_pc, instr, 1'b1);
    check({tag, "_pc"}, pc, exp_pc + 32'd4);
  endtask

  initial begin
    rstn        = 1'b0;
    redirect    = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = BAD;
    tgt         = 32'h0;

    // 1. Reset values, then back-to-back fetches at 2 cycles each.
    step();
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check_if_id("rst", 32'h0, NOP, 1'b0);
    rstn = 1'b1;
    step();
    fetch("f0", I0, 32'h0);
    fetch("f1", I1, 32'h4);
    fetch("f2", I2, 32'h8);

    // 2. Redirect while in WAIT; the late response is dropped.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect = 1'b1;
    tgt      = 32'h100;
    step();
    redirect = 1'b0;
    check("t2_pc", pc, 32'h100);
    check_if_id("t2_kill", 32'h8, NOP, 1'b0);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = BAD;
    step();
    imem_rvalid = 1'b0;
    check("t2_drop_valid", {31'd0, if_id_valid}, 32'd0);
    check("t2_drop_pc", pc, 32'h100);
    fetch("t2_f", I4, 32'h100);

    // 3. Response arrives during a 3-cycle stall and is parked in the skid buffer.
    stall    = 1'b1;
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = I3;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = BAD;
    for (int i = 0; i < 2; i++) begin
      check_if_id("t3_hold", 32'h100, I4, 1'b1);
      check("t3_req", {31'd0, imem_req}, 32'd0);
      check("t3_pc", pc, 32'h104);
      step();
    end
    check_if_id("t3_hold_last", 32'h100, I4, 1'b1);
    stall = 1'b0;
    step();
    check_if_id("t3_skid", 32'h104, I3, 1'b1);
    check("t3_pc_adv", pc, 32'h108);

    // 4. Stall plus redirect in FULL: the skid entry is discarded.
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    stall       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = I5;
    step();
    imem_rvalid = 1'b0;
    check("t4_full_req", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1;
    tgt      = 32'h200;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    check_if_id("t4_kill", 32'h104, NOP, 1'b0);
    check("t4_pc", pc, 32'h200);
    fetch("t4_f", I0, 32'h200);

    // 5. Redirect and gnt in the same REQ cycle: the granted response is dropped.
    redirect = 1'b1;
    imem_gnt = 1'b1;
    tgt      = 32'h1c09_0000;
    step();
    redirect = 1'b0;
    imem_gnt = 1'b0;
    check("t5_pc", pc, 32'h1c09_0000);
    check("t5_drop_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = BAD;
    step();
    imem_rvalid = 1'b0;
    check("t5_drop_valid", {31'd0, if_id_valid}, 32'd0);
    fetch("t5_f", I1, 32'h1c09_0000);

    // Redirect in REQ without gnt: the address moves before the grant.
    redirect = 1'b1;
    tgt      = 32'h300;
    step();
    redirect = 1'b0;
    check("rq_redir_req", {31'd0, imem_req}, 32'd1);
    fetch("rq_f", I2, 32'h300);

    // Flush alone invalidates IF/ID but keeps the PC.
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_if_id("flush", 32'h300, NOP, 1'b0);
    check("flush_pc", pc, 32'h304);

    // 6. Asynchronous reset in the middle of WAIT.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rstn     = 1'b0;
    #1;
    check("t6_pc", pc, 32'h0);
    check("t6_req", {31'd0, imem_req}, 32'd0);
    check_if_id("t6", 32'h0, NOP, 1'b0);
    step();
    rstn = 1'b1;
    step();
    fetch("t6_f", I3, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
